// File: rtl/channel_activity_detector.sv
// Windowed |I|+|Q| energy detector with on/hang hysteresis; gates samples through when the channel is on.
// Optional CHANNEL_DET_AVG_OUT_EN adds avg_level/avg_valid outputs reporting each window average.
module channel_activity_detector #(
  parameter int WIN_LOG2  = 6,
  parameter int ON_WINS   = 2,
  parameter int HANG_WINS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] in_bus,
  input  logic        in_valid,
  input  logic [16:0] thr_on,
  input  logic [16:0] thr_off,
  output logic        mode,
  output logic [31:0] out_bus,
  output logic        out_valid
`ifdef CHANNEL_DET_AVG_OUT_EN
  ,
  output logic [16:0] avg_level,
  output logic        avg_valid
`endif
);

  localparam int ACC_W = 17 + WIN_LOG2;
  localparam logic [WIN_LOG2-1:0] CNT_ONE = 1;

  typedef enum logic [1:0] {IDLE, ARM, ACTIVE, HANG} state_t;

  state_t              state_reg, state_next;
  logic [3:0]          on_cnt_reg, on_cnt_next;
  logic [3:0]          hang_cnt_reg, hang_cnt_next;
  logic [ACC_W-1:0]    acc_reg;
  logic [WIN_LOG2-1:0] cnt_reg;

  logic [16:0]      i_ext, q_ext, abs_i, abs_q, mag, avg;
  logic [ACC_W-1:0] acc_sum;
  logic             win_end, mode_next;

  // Sign-extend before negating so that -32768 maps to +32768 without wrap.
  assign i_ext   = {in_bus[31], in_bus[31:16]};
  assign q_ext   = {in_bus[15], in_bus[15:0]};
  assign abs_i   = i_ext[16] ? (17'd0 - i_ext) : i_ext;
  assign abs_q   = q_ext[16] ? (17'd0 - q_ext) : q_ext;
  assign mag     = abs_i + abs_q;
  assign acc_sum = acc_reg + ACC_W'(mag);
  assign win_end = in_valid && (cnt_reg == '1);
  assign avg     = acc_sum[ACC_W-1:WIN_LOG2];

  always_comb begin
    state_next    = state_reg;
    on_cnt_next   = on_cnt_reg;
    hang_cnt_next = hang_cnt_reg;
    if (win_end) begin
      case (state_reg)
        IDLE: begin
          if (avg >= thr_on) begin
            if (ON_WINS == 1) begin
              state_next = ACTIVE;
            end else begin
              state_next  = ARM;
              on_cnt_next = 4'd1;
            end
          end
        end
        ARM: begin
          if (avg >= thr_on) begin
            if (on_cnt_reg + 4'd1 == 4'(ON_WINS)) begin
              state_next  = ACTIVE;
              on_cnt_next = 4'd0;
            end else begin
              on_cnt_next = on_cnt_reg + 4'd1;
            end
          end else begin
            state_next  = IDLE;
            on_cnt_next = 4'd0;
          end
        end
        ACTIVE: begin
          if (avg < thr_off) begin
            if (HANG_WINS == 1) begin
              state_next = IDLE;
            end else begin
              state_next    = HANG;
              hang_cnt_next = 4'd1;
            end
          end
        end
        default: begin
          if (avg >= thr_off) begin
            state_next    = ACTIVE;
            hang_cnt_next = 4'd0;
          end else if (hang_cnt_reg + 4'd1 == 4'(HANG_WINS)) begin
            state_next    = IDLE;
            hang_cnt_next = 4'd0;
          end else begin
            hang_cnt_next = hang_cnt_reg + 4'd1;
          end
        end
      endcase
    end
  end

  assign mode_next = (state_next == ACTIVE) || (state_next == HANG);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      on_cnt_reg   <= 4'd0;
      hang_cnt_reg <= 4'd0;
      acc_reg      <= '0;
      cnt_reg      <= '0;
      mode         <= 1'b0;
      out_bus      <= 32'd0;
      out_valid    <= 1'b0;
    end else begin
      state_reg    <= state_next;
      on_cnt_reg   <= on_cnt_next;
      hang_cnt_reg <= hang_cnt_next;
      mode         <= mode_next;
      out_bus      <= mode_next ? in_bus : 32'd0;
      out_valid    <= in_valid;
      if (win_end) begin
        acc_reg <= '0;
        cnt_reg <= '0;
      end else if (in_valid) begin
        acc_reg <= acc_sum;
        cnt_reg <= cnt_reg + CNT_ONE;
      end
    end
  end

`ifdef CHANNEL_DET_AVG_OUT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      avg_level <= 17'd0;
      avg_valid <= 1'b0;
    end else begin
      avg_valid <= win_end;
      if (win_end) begin
        avg_level <= avg;
      end
    end
  end
`endif

endmodule

// File: tb/tb_channel_activity_detector.sv
// Randomized and directed bench for channel_activity_detector against a window-average reference model.
module tb_channel_activity_detector;

  localparam int W    = 2;
  localparam int ON   = 2;
  localparam int HANG = 4;
  localparam int W2   = 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1, in_valid = 1'b0;
  logic [31:0] in_bus = 32'd0;
  logic [16:0] thr_on = 17'd0, thr_off = 17'd0;
  logic        mode, out_valid;
  logic [31:0] out_bus;

  logic        rst2 = 1'b1, in_valid2 = 1'b0;
  logic [31:0] in_bus2 = 32'd0;
  logic [16:0] thr_on2 = 17'd0, thr_off2 = 17'd0;
  logic        mode2, out_valid2;
  logic [31:0] out_bus2;

`ifdef CHANNEL_DET_AVG_OUT_EN
  logic [16:0] avg_level, avg_level2;
  logic        avg_valid, avg_valid2;
`endif

  channel_activity_detector #(.WIN_LOG2(W), .ON_WINS(ON), .HANG_WINS(HANG)) dut (
    .clk(clk), .rst(rst), .in_bus(in_bus), .in_valid(in_valid),
    .thr_on(thr_on), .thr_off(thr_off),
    .mode(mode), .out_bus(out_bus), .out_valid(out_valid)
`ifdef CHANNEL_DET_AVG_OUT_EN
    , .avg_level(avg_level), .avg_valid(avg_valid)
`endif
  );

  channel_activity_detector #(.WIN_LOG2(W2), .ON_WINS(2), .HANG_WINS(4)) dut_big (
    .clk(clk), .rst(rst2), .in_bus(in_bus2), .in_valid(in_valid2),
    .thr_on(thr_on2), .thr_off(thr_off2),
    .mode(mode2), .out_bus(out_bus2), .out_valid(out_valid2)
`ifdef CHANNEL_DET_AVG_OUT_EN
    , .avg_level(avg_level2), .avg_valid(avg_valid2)
`endif
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    else n_pass++;
  endtask

  // Reference model: plain sums over a window and run-length counts of qualifying windows.
  longint m_sum;
  int     m_cnt, m_above, m_below;
  bit     m_on;
  logic [31:0] e_out_bus;
  logic        e_out_valid, e_avg_valid;
  logic [16:0] e_avg_level;

  function automatic int iabs(input logic [15:0] x);
    int v;
    v = int'($signed(x));
    return (v < 0) ? -v : v;
  endfunction

  task automatic model_step(input bit r, input bit v, input logic [31:0] b,
                            input logic [16:0] ton, input logic [16:0] toff);
    longint avg;
    e_avg_valid = 1'b0;
    if (r) begin
      m_sum = 0; m_cnt = 0; m_above = 0; m_below = 0; m_on = 1'b0;
      e_out_bus = 32'd0; e_out_valid = 1'b0; e_avg_level = 17'd0;
    end else begin
      e_out_valid = v;
      if (v) begin
        m_sum += iabs(b[31:16]) + iabs(b[15:0]);
        m_cnt++;
        if (m_cnt == (1 << W)) begin
          avg = m_sum / (1 << W);
          e_avg_level = 17'(avg);
          e_avg_valid = 1'b1;
          if (!m_on) begin
            m_above = (avg >= longint'(ton)) ? m_above + 1 : 0;
            if (m_above >= ON) begin m_on = 1'b1; m_above = 0; end
          end else begin
            m_below = (avg < longint'(toff)) ? m_below + 1 : 0;
            if (m_below >= HANG) begin m_on = 1'b0; m_below = 0; end
          end
          m_sum = 0; m_cnt = 0;
        end
      end
      e_out_bus = m_on ? b : 32'd0;
    end
  endtask

  task automatic cyc(input bit r, input bit v, input logic [31:0] b,
                     input logic [16:0] ton, input logic [16:0] toff);
    @(negedge clk);
    rst = r; in_valid = v; in_bus = b; thr_on = ton; thr_off = toff;
    @(posedge clk);
    model_step(r, v, b, ton, toff);
    #1;
    chk("mode", {63'd0, mode}, {63'd0, m_on});
    chk("out_bus", {32'd0, out_bus}, {32'd0, e_out_bus});
    chk("out_valid", {63'd0, out_valid}, {63'd0, e_out_valid});
`ifdef CHANNEL_DET_AVG_OUT_EN
    chk("avg_valid", {63'd0, avg_valid}, {63'd0, e_avg_valid});
    chk("avg_level", {47'd0, avg_level}, {47'd0, e_avg_level});
`endif
  endtask

  function automatic logic [31:0] iq(input int i, input int q);
    logic [15:0] ii, qq;
    ii = 16'(i); qq = 16'(q);
    return {ii, qq};
  endfunction

  initial begin
    logic [31:0] s;
    int amp, ton_i;

    // Reset state
    repeat (2) cyc(1, 0, 32'hFFFF_FFFF, 17'd0, 17'd0);
    chk("reset_mode", {63'd0, mode}, 64'd0);

    // Strong constant signal: mode rises after the second full window
    for (int k = 0; k < 10; k++) begin
      cyc(0, 1, iq(1000, -1000), 17'd1500, 17'd500);
      if (k == 6) chk("rise_pre", {63'd0, mode}, 64'd0);
      if (k == 7) chk("rise_8th", {63'd0, mode}, 64'd1);
      if (k == 7) chk("rise_bus", {32'd0, out_bus}, {32'd0, iq(1000, -1000)});
    end
    cyc(0, 1, iq(1000, -1000), 17'd1500, 17'd500);  // realign to a window boundary
    cyc(0, 1, iq(1000, -1000), 17'd1500, 17'd500);

    // Four silent windows drop the channel on the 16th zero sample
    for (int k = 0; k < 16; k++) begin
      cyc(0, 1, 32'd0, 17'd1500, 17'd500);
      if (k == 14) chk("hang_hold", {63'd0, mode}, 64'd1);
      if (k == 15) chk("fall_16th", {63'd0, mode}, 64'd0);
    end

    // Re-activate, hang two windows, then a 600-average window resumes ACTIVE
    repeat (8) cyc(0, 1, iq(1000, -1000), 17'd1500, 17'd500);
    repeat (8) cyc(0, 1, 32'd0, 17'd1500, 17'd500);
    repeat (4) cyc(0, 1, iq(300, -300), 17'd1500, 17'd500);
    chk("hang_resume", {63'd0, mode}, 64'd1);
    repeat (12) cyc(0, 1, 32'd0, 17'd1500, 17'd500);
    chk("hang_restart", {63'd0, mode}, 64'd1);
    repeat (4) cyc(0, 1, 32'd0, 17'd1500, 17'd500);
    chk("fall_again", {63'd0, mode}, 64'd0);

    // Valid on alternate cycles: windows count samples, not cycles
    for (int k = 0; k < 32; k++) cyc(0, k[0], iq(2000, 0), 17'd1500, 17'd500);
    chk("toggle_on", {63'd0, mode}, 64'd1);

    // Reset in ARM after 3 of 4 samples discards the partial window
    cyc(1, 1, iq(2000, 0), 17'd1500, 17'd500);
    repeat (7) cyc(0, 1, iq(2000, 0), 17'd1500, 17'd500);
    cyc(1, 1, iq(2000, 0), 17'd1500, 17'd500);
    chk("rst_arm_mode", {63'd0, mode}, 64'd0);
    chk("rst_arm_ov", {63'd0, out_valid}, 64'd0);
    repeat (4) cyc(0, 1, iq(2000, 0), 17'd1500, 17'd500);
    chk("rst_arm_first", {63'd0, mode}, 64'd0);
    repeat (4) cyc(0, 1, iq(2000, 0), 17'd1500, 17'd500);
    chk("rst_arm_second", {63'd0, mode}, 64'd1);

    // Randomized traffic with thresholds changing every cycle
    amp = 1000;
    for (int k = 0; k < 1500; k++) begin
      if (k % 40 == 0) begin
        case ($urandom_range(0, 3))
          0: amp = 0;
          1: amp = 200;
          2: amp = 1000;
          default: amp = 32768;
        endcase
      end
      s = (amp == 0) ? 32'd0 :
          iq(int'($urandom_range(0, 2 * amp)) - amp, int'($urandom_range(0, 2 * amp)) - amp);
      ton_i = int'($urandom_range(0, 2 * amp + 100));
      cyc($urandom_range(0, 299) == 0, $urandom_range(0, 3) != 0, s,
          17'(ton_i), 17'($urandom_range(0, ton_i)));
    end

    // Full-scale negative samples at the largest window: average must reach 65536
    @(negedge clk);
    rst2 = 1'b1;
    @(negedge clk);
    rst2 = 1'b0; in_valid2 = 1'b1; in_bus2 = 32'h8000_8000;
    thr_on2 = 17'd65536; thr_off2 = 17'd65536;
    repeat ((1 << W2) - 1) @(negedge clk);
    chk("big_pre1", {63'd0, mode2}, 64'd0);
    repeat (1 << W2) @(negedge clk);
    chk("big_pre2", {63'd0, mode2}, 64'd0);
`ifdef CHANNEL_DET_AVG_OUT_EN
    chk("big_avg_level", {47'd0, avg_level2}, 64'd65536);
`endif
    @(negedge clk);
    chk("big_on", {63'd0, mode2}, 64'd1);
    chk("big_bus", {32'd0, out_bus2}, 64'h8000_8000);
    chk("big_ov", {63'd0, out_valid2}, 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
